// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
package reg_file_pkg;

  localparam int REG_BIT_WIDTH_D = 32;
  localparam int NUM_OF_REGS_D   = 32;
  localparam int ZERO_REG        = 0;

  function automatic int rf_addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard; reservations from issue, releases from writeback.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int  NUM_OF_REGS = NUM_OF_REGS_D,
  localparam int ADDR_W      = rf_addr_w(NUM_OF_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_set_en,
  input  logic [ADDR_W-1:0]      i_set_addr,
  input  logic [NUM_OF_REGS-1:0] i_clr,
  output logic [NUM_OF_REGS-1:0] o_busy
);

  logic [NUM_OF_REGS-1:0] r_busy;

  // A set wins over a clear on the same edge: the reservation belongs to the newer instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NUM_OF_REGS; r++) begin
        if (r == ZERO_REG) begin
          r_busy[r] <= 1'b0;
        end else if (i_set_en && (i_set_addr == ADDR_W'(r))) begin
          r_busy[r] <= 1'b1;
        end else if (i_clr[r]) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with x0 hardwired to zero and a RAW scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int  REG_BIT_WIDTH = REG_BIT_WIDTH_D,
  parameter int  NUM_OF_REGS   = NUM_OF_REGS_D,
  parameter int  NUM_RD_PORTS  = 2,
  parameter int  NUM_WR_PORTS  = 1,
  localparam int ADDR_W        = rf_addr_w(NUM_OF_REGS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]       rs_addr,
  output logic [NUM_RD_PORTS*REG_BIT_WIDTH-1:0] rs_data,
  output logic [NUM_RD_PORTS-1:0]              rs_busy,
  input  logic [NUM_WR_PORTS-1:0]              rd_wr_en,
  input  logic [NUM_WR_PORTS*ADDR_W-1:0]       rd_addr,
  input  logic [NUM_WR_PORTS*REG_BIT_WIDTH-1:0] rd_data,
  input  logic                                 sb_set_en,
  input  logic [ADDR_W-1:0]                    sb_set_addr,
  output logic [NUM_OF_REGS*REG_BIT_WIDTH-1:0] regs_out
);

  logic [REG_BIT_WIDTH-1:0] r_regs   [NUM_OF_REGS];
  logic [REG_BIT_WIDTH-1:0] w_wr_val [NUM_OF_REGS];
  logic [NUM_OF_REGS-1:0]   w_wr_hit;
  logic [NUM_OF_REGS-1:0]   w_busy;

  // Later ports overwrite earlier ones, so the highest-index writer wins a collision.
  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < NUM_OF_REGS; r++) begin
      w_wr_val[r] = '0;
    end
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (rd_wr_en[w] && (rd_addr[w*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
        w_wr_hit[rd_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
        w_wr_val[rd_addr[w*ADDR_W +: ADDR_W]] = rd_data[w*REG_BIT_WIDTH +: REG_BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_OF_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_OF_REGS; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_val[r];
        end
      end
    end
  end

  rf_scoreboard #(
    .NUM_OF_REGS(NUM_OF_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (sb_set_en),
    .i_set_addr (sb_set_addr),
    .i_clr      (w_wr_hit),
    .o_busy     (w_busy)
  );

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] w_idx;
    assign w_idx = rs_addr[p*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
    // A hit never targets x0, so the set comparison needs no zero guard here.
    assign rs_data[p*REG_BIT_WIDTH +: REG_BIT_WIDTH] = w_wr_hit[w_idx] ? w_wr_val[w_idx] : r_regs[w_idx];
    assign rs_busy[p] = w_wr_hit[w_idx] ? (sb_set_en && (sb_set_addr == w_idx)) : w_busy[w_idx];
`else
    assign rs_data[p*REG_BIT_WIDTH +: REG_BIT_WIDTH] = r_regs[w_idx];
    assign rs_busy[p] = w_busy[w_idx];
`endif
  end

  for (genvar r = 0; r < NUM_OF_REGS; r++) begin : g_dbg
    assign regs_out[r*REG_BIT_WIDTH +: REG_BIT_WIDTH] = r_regs[r];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised self-checking bench for reg_file_mp against an array-based model.
// Model follows REG_FILE_BYPASS_EN when the macro is defined.
module tb_reg_file_mp;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int RD = 2;
  localparam int WR = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [RD*AW-1:0] rs_addr;
  logic [RD*W-1:0]  rs_data;
  logic [RD-1:0]    rs_busy;
  logic [WR-1:0]    rd_wr_en;
  logic [WR*AW-1:0] rd_addr;
  logic [WR*W-1:0]  rd_data;
  logic             sb_set_en;
  logic [AW-1:0]    sb_set_addr;
  logic [N*W-1:0]   regs_out;

  int checkCount = 0;
  int failCount  = 0;

  logic [W-1:0] modelRegs [N];
  logic         modelBusy [N];

  reg_file_mp #(
    .REG_BIT_WIDTH (W),
    .NUM_OF_REGS   (N),
    .NUM_RD_PORTS  (RD),
    .NUM_WR_PORTS  (WR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .rd_wr_en    (rd_wr_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .regs_out    (regs_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N*W-1:0] observed, input logic [N*W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < N; r++) begin
      modelRegs[r] = '0;
      modelBusy[r] = 1'b0;
    end
  endtask

  // Highest-index port writing addr this cycle, or -1.
  function automatic int writerOf(input int addr);
    int who = -1;
    for (int w = 0; w < WR; w++)
      if (rd_wr_en[w] && int'(rd_addr[w*AW +: AW]) == addr && addr != 0) who = w;
    return who;
  endfunction

  function automatic logic [W-1:0] expData(input int addr);
`ifdef REG_FILE_BYPASS_EN
    int who = writerOf(addr);
    if (who >= 0) return rd_data[who*W +: W];
`endif
    return modelRegs[addr];
  endfunction

  function automatic logic expBusy(input int addr);
`ifdef REG_FILE_BYPASS_EN
    if (writerOf(addr) >= 0) return sb_set_en && int'(sb_set_addr) == addr;
`endif
    return modelBusy[addr];
  endfunction

  function automatic logic [N*W-1:0] expRegsOut();
    logic [N*W-1:0] v;
    for (int r = 0; r < N; r++) v[r*W +: W] = modelRegs[r];
    return v;
  endfunction

  task automatic checkReads();
    for (int p = 0; p < RD; p++) begin
      int a = int'(rs_addr[p*AW +: AW]);
      checkOutput($sformatf("rs_data%0d@%0d", p, a), {{(N*W-W){1'b0}}, rs_data[p*W +: W]}, {{(N*W-W){1'b0}}, expData(a)});
      checkOutput($sformatf("rs_busy%0d@%0d", p, a), {{(N*W-1){1'b0}}, rs_busy[p]}, {{(N*W-1){1'b0}}, expBusy(a)});
    end
    checkOutput("regs_out", regs_out, expRegsOut());
  endtask

  task automatic updateModel();
    if (!rst) begin
      modelReset();
      return;
    end
    for (int w = 0; w < WR; w++) begin
      int a = int'(rd_addr[w*AW +: AW]);
      if (rd_wr_en[w] && a != 0) begin
        modelRegs[a] = rd_data[w*W +: W];
        modelBusy[a] = 1'b0;
      end
    end
    if (sb_set_en && sb_set_addr != 0) modelBusy[sb_set_addr] = 1'b1;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic stepCycle();
    #1;
    checkReads();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en0, input int a0, input logic [W-1:0] d0,
                               input logic en1, input int a1, input logic [W-1:0] d1,
                               input logic setEn, input int setA, input int r0, input int r1);
    rd_wr_en    = {en1, en0};
    rd_addr     = {AW'(a1), AW'(a0)};
    rd_data     = {d1, d0};
    sb_set_en   = setEn;
    sb_set_addr = AW'(setA);
    rs_addr     = {AW'(r1), AW'(r0)};
  endtask

  initial begin
    rst = 1'b0;
    modelReset();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
    @(negedge clk);

    // Writes and reservations under reset must all be dropped.
    for (int a = 0; a < N; a++) begin
      applyStimulus(1, a, 32'hdeadbeef, 1, a, 32'hdeadbeef, 1, a, a, (a + 7) % N);
      stepCycle();
    end

    rst = 1'b1;
    applyStimulus(1, 4, 32'h0badf00d, 0, 0, '0, 0, 0, 4, 4);
    stepCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 4, 4);
    stepCycle();

    for (int a = 1; a < N; a++) begin
      applyStimulus(1, a, 32'hdeadbeef ^ W'(a), 0, 0, '0, 0, 0, a, a);
      stepCycle();
    end
    applyStimulus(1, 0, 32'hffffffff, 0, 0, '0, 0, 0, 0, 0);
    stepCycle();
    for (int a = 0; a < N; a++) begin
      applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, a, (N - 1) - a);
      stepCycle();
    end

    applyStimulus(1, 5, 32'h1111, 1, 5, 32'h2222, 0, 0, 5, 5);
    stepCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 5, 5);
    stepCycle();

    applyStimulus(0, 0, '0, 0, 0, '0, 1, 7, 7, 7);
    stepCycle();
    applyStimulus(1, 7, 32'h77, 0, 0, '0, 0, 0, 7, 7);
    stepCycle();
    applyStimulus(1, 7, 32'h78, 0, 0, '0, 1, 7, 7, 7);
    stepCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 0, 7, 0);
    stepCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 7, 0);
    stepCycle();

    applyStimulus(1, 9, 32'hcafef00d, 0, 0, '0, 0, 0, 9, 9);
    stepCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 9, 9);
    stepCycle();

    // Narrow address range so collisions and set/clear overlaps happen often.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 7), W'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7), W'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, N - 1));
      stepCycle();
    end

    applyStimulus(1, 3, 32'h55, 0, 0, '0, 1, 3, 3, 3);
    stepCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 3, 3);
    #1;
    checkReads();
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkReads();
    @(negedge clk);
    rst = 1'b1;
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the two-read/one-write `reg_file`. It provides a configurable number of combinational read ports and synchronous write ports, with x0 hardwired to zero. A per-register pending-write scoreboard lets the decode/issue stage detect RAW hazards. Optional same-cycle write-to-read bypass is compiled in by macro. It sits between decode (read and reserve) and writeback (write and release).

## Interface
- `REG_BIT_WIDTH`, 32, data width of each register.
- `NUM_OF_REGS`, 32, register count; power of two, ≥2; address width `ADDR_W = $clog2(NUM_OF_REGS)`.
- `NUM_RD_PORTS`, 2, number of read ports, 1..8.
- `NUM_WR_PORTS`, 1, number of write ports, 1..4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rs_addr`  in  NUM_RD_PORTS×ADDR_W  read addresses, packed, port 0 in the LSBs.
- `rs_data`  out  NUM_RD_PORTS×REG_BIT_WIDTH  read data, combinational.
- `rs_busy`  out  NUM_RD_PORTS  scoreboard pending bit for each read address.
- `rd_wr_en`  in  NUM_WR_PORTS  write enables.
- `rd_addr`  in  NUM_WR_PORTS×ADDR_W  write addresses.
- `rd_data`  in  NUM_WR_PORTS×REG_BIT_WIDTH  write data.
- `sb_set_en`  in  1  reserve the register at `sb_set_addr` (instruction issued).
- `sb_set_addr`  in  ADDR_W  destination to reserve.
- `regs_out`  out  NUM_OF_REGS×REG_BIT_WIDTH  debug view of all registers.

## Operation
- Storage is `regs[NUM_OF_REGS]` plus `busy[NUM_OF_REGS]`.
- Write: on the rising edge, each port `w` with `rd_wr_en[w]=1` and `rd_addr[w]≠0` loads `rd_data[w]`.
- Write collision: when several ports write the same address, the highest port index wins. No error is flagged.
- x0: writes are ignored. `regs[0]` and `busy[0]` are always 0, and `sb_set_en` to address 0 has no effect.
- Read: `rs_data[p] = regs[rs_addr[p]]` and `rs_busy[p] = busy[rs_addr[p]]`. Both are combinational with no read-enable.
- Scoreboard clear: any accepted write to register `r` clears `busy[r]` on the same edge.
- Scoreboard set: `sb_set_en` sets `busy[sb_set_addr]`. Set and clear of the same register on the same edge leaves it set, because the reservation belongs to the newer instruction. Setting an already-busy register keeps it busy.
- Address out of range (non-power-of-two is disallowed) is not applicable; all addresses are valid.

## Timing
- Reset: `rst=0` immediately forces every register and busy bit to 0, independent of `clk`. As a result, `rs_data`, `rs_busy` and `regs_out` all read 0.
- A write or scoreboard operation on the edge coincident with reset release is ignored. The first accepted update is on the following edge.
- Reset asserted mid-operation discards pending writes and reservations.
- Write latency: data is visible on `rs_data` and `regs_out` after the edge, i.e. one cycle after the write request. This holds without bypass.
- Busy latency: set is visible the cycle after `sb_set_en`; clear is visible the cycle after the write.
- Reads have zero latency from address change (combinational path).

## Configuration
- `REG_FILE_BYPASS_EN` defined:
  - `rs_data[p]` returns `rd_data[w]` of the highest-index port writing `rs_addr[p]≠0` this cycle.
  - `rs_busy[p]` reads 0 for that address, unless `sb_set_en` targets the same address this cycle.
  - This gives write-first behaviour with zero-cycle forwarding.
- Undefined: reads are read-before-write and return the old value during the write cycle. `rs_busy` reflects stored state only.
- `regs_out` is never bypassed.

## Structure
- Package `reg_file_pkg`:
  - default parameter constants `REG_BIT_WIDTH_D`, `NUM_OF_REGS_D`;
  - `localparam ZERO_REG = 0`;
  - function `rf_addr_w(n)` returning `$clog2(n)`.
- Sub-module `rf_scoreboard`:
  - holds `busy[]`;
  - inputs: set port, write-port clear vector, async reset;
  - outputs: the busy vector.
- The top level holds the register array, write-priority logic, read muxes and the optional bypass.

## Test plan
- **Reset:** hold `rst=0`, drive writes of 32'hdeadbeef to all addresses → every `regs_out` entry and `rs_data` read 0, `rs_busy` all 0. Release reset → first write lands on the next edge.
- **Sweep:** write 32'hdeadbeef ^ addr to addresses 1..31 on port 0, then read each on every read port → data matches. Address 0 reads 0 after a write of 32'hffffffff.
- **Collision:** `NUM_WR_PORTS=2`, both write addr 5 with port0=32'h1111, port1=32'h2222 → reg5=32'h2222.
- **Scoreboard:**
  - set addr 7 → `rs_busy` for addr 7 goes 1 the next cycle;
  - write addr 7 → busy goes 0 the next cycle;
  - set and write addr 7 in the same cycle → busy stays 1;
  - set addr 0 → busy stays 0.
- **Bypass (`REG_FILE_BYPASS_EN`):** write 32'hcafef00d to addr 9 while reading addr 9 → `rs_data`=32'hcafef00d in the same cycle. Without the macro → old value that cycle, new value the next.
- **Mid-op reset:** busy set on addr 3 with reg3=32'h55; assert `rst=0` between edges → both read 0 immediately.
